pwm_duty_decoder: RTL

Measures the duty cycle of an incoming PWM waveform and reports it as a brightness level from 0 to STEPS. It is the receive-side counterpart of the LED PWM drivers: it sits on a board input or a loopback of an LED line, and gives self-test and brightness-readback logic the same 0..STEPS scale the drivers use. Measurement runs continuously. Each complete PWM period produces one `level` result through a sequential divider.

---
 rtl/pwm_duty_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures the duty cycle of an asynchronous PWM input and reports it as 0..STEPS.
// Optional glitch filter between synchronizer and edge detector: define PWM_DEC_GLITCH_FILTER_EN.
//
// state  | meaning
// S_IDLE | counters held at 0, waiting for the first rising edge (also after a stuck timeout)
// S_MEAS | counting a period; each rising edge snapshots and restarts the counters
module pwm_duty_decoder #(
  parameter  int STEPS       = 100,
  parameter  int TIMEOUT_CLK = 200_000,
  parameter  int FILTER_LEN  = 4,
  localparam int W           = $clog2(TIMEOUT_CLK + 1),
  localparam int LW          = $clog2(STEPS + 1),
  localparam int NUM_W       = W + LW,
  localparam int DIV_CYCLES  = NUM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  output logic [LW-1:0] level,
  output logic [W-1:0]  high_cnt,
  output logic [W-1:0]  period_cnt,
  output logic          level_valid,
  output logic          busy,
  output logic          stuck
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_MEAS = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_pwm_s, r_pwm_d, w_rise, w_edge;
  logic [W-1:0]  r_per, r_hi, r_wd;
  logic          w_restart, w_snap, w_timeout, w_wd_exp;
  logic          r_busy, w_div_done, w_start;
  logic [CW-1:0] r_div_cnt;
  logic [NUM_W-1:0] r_quo, w_prod;
  logic [W-1:0]  r_rem, r_div_per, r_div_hi;
  logic [W:0]    w_rem_sh, w_trial;
  logic [LW-1:0] w_level_clamp, r_level;
  logic [W-1:0]  r_high_cnt, r_period_cnt;
  logic          r_level_valid, r_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], pwm_in};
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] r_flt_cnt;
  logic          r_flt;

  // the filtered level follows only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_cnt <= '0;
      r_flt     <= 1'b0;
    end else if (r_sync[1] == r_flt) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
      r_flt     <= r_sync[1];
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end
  assign w_pwm_s = r_flt;
`else
  assign w_pwm_s = r_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_d <= 1'b0;
    else        r_pwm_d <= w_pwm_s;
  end
  assign w_rise   = w_pwm_s & ~r_pwm_d;
  assign w_edge   = w_pwm_s ^ r_pwm_d;
  assign w_wd_exp = ~w_edge && (r_wd == W'(TIMEOUT_CLK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_snap      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_restart   = 1'b1;
          w_state_nxt = S_MEAS;
        end
      end
      S_MEAS: begin
        if (w_rise) begin
          w_restart = 1'b1;
          w_snap    = 1'b1;
        end else if (w_wd_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per <= '0;
      r_hi  <= '0;
      r_wd  <= '0;
    end else if (w_restart) begin
      r_per <= W'(1);
      r_hi  <= W'(1);
      r_wd  <= '0;
    end else if (w_timeout || (r_state == S_IDLE)) begin
      r_per <= '0;
      r_hi  <= '0;
      r_wd  <= '0;
    end else begin
      if (r_per != W'(TIMEOUT_CLK)) r_per <= r_per + 1'b1;
      if (w_pwm_s && (r_hi != W'(TIMEOUT_CLK))) r_hi <= r_hi + 1'b1;
      if (w_edge) r_wd <= '0;
      else if (r_wd != W'(TIMEOUT_CLK)) r_wd <= r_wd + 1'b1;
    end
  end

  // a snapshot taken on the completion cycle is accepted, keeping busy high
  assign w_div_done = r_busy && (r_div_cnt == '0);
  assign w_start    = w_snap && (!r_busy || w_div_done);
  assign w_prod     = NUM_W'(r_hi) * NUM_W'(STEPS);
  assign w_rem_sh   = {r_rem, r_quo[NUM_W-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_div_per};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_div_cnt <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div_per <= '0;
      r_div_hi  <= '0;
    end else if (w_start) begin
      r_busy    <= 1'b1;
      r_div_cnt <= CW'(DIV_CYCLES);
      r_quo     <= w_prod;
      r_rem     <= '0;
      r_div_per <= r_per;
      r_div_hi  <= r_hi;
    end else if (r_busy) begin
      if (r_div_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_div_cnt <= r_div_cnt - 1'b1;
        r_quo     <= {r_quo[NUM_W-2:0], ~w_trial[W]};
        r_rem     <= w_trial[W] ? w_rem_sh[W-1:0] : w_trial[W-1:0];
      end
    end
  end

  assign w_level_clamp = (r_quo > NUM_W'(STEPS)) ? LW'(STEPS) : r_quo[LW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level       <= '0;
      r_high_cnt    <= '0;
      r_period_cnt  <= '0;
      r_level_valid <= 1'b0;
      r_stuck       <= 1'b0;
    end else begin
      r_level_valid <= 1'b0;
      if (w_timeout) begin
        r_stuck       <= 1'b1;
        r_level       <= w_pwm_s ? LW'(STEPS) : '0;
        r_high_cnt    <= '0;
        r_period_cnt  <= '0;
        r_level_valid <= 1'b1;
      end else begin
        if (w_rise) r_stuck <= 1'b0;
        if (w_div_done) begin
          r_level       <= w_level_clamp;
          r_high_cnt    <= r_div_hi;
          r_period_cnt  <= r_div_per;
          r_level_valid <= 1'b1;
        end
      end
    end
  end

  assign level       = r_level;
  assign high_cnt    = r_high_cnt;
  assign period_cnt  = r_period_cnt;
  assign level_valid = r_level_valid;
  assign busy        = r_busy;
  assign stuck       = r_stuck;

endmodule
